lif_param_loader: RTL and testbench
===================================

# lif_param_loader

Bit-serial configuration loader for a bank of leaky-integrate-fire neurons. Three serial lines (tau, weight, threshold) are shifted in under a frame gate. At frame end the assembled words are committed atomically to the neuron selected at frame start. Frame-length and index errors are flagged, and a faulty frame never disturbs committed values. The block sits between the host/config interface and the neuron array, and supplies each neuron's parameters as flat buses.

## Interface
- `DATA_W`, 8, width of each parameter word (≥2)
- `N_NEURONS`, 4, number of neurons configured (≥1)
- `IDX_W`, `$clog2(N_NEURONS)` (min 1), width of neuron select
- `clk` input 1: single clock, all logic on rising edge
- `rst` input 1: synchronous, active-high reset
- `set_vars` input 1: frame gate; high for exactly `DATA_W` consecutive cycles per frame
- `sel` input `IDX_W`: target neuron, sampled on the first high cycle of a frame
- `expd` input 1: serial tau bit, LSB first
- `w` input 1: serial weight bit, LSB first
- `t` input 1: serial threshold bit, LSB first
- `tau` output `N_NEURONS*DATA_W`: committed tau words; neuron i occupies bits `[i*DATA_W +: DATA_W]`
- `weight` output `N_NEURONS*DATA_W`: committed weights, same packing
- `threshold` output `N_NEURONS*DATA_W`: committed thresholds, same packing
- `cfg_valid` output `N_NEURONS`: bit i set once neuron i has had a successful commit
- `busy` output 1: high while a frame is being received (states `SHIFT`/`OVER`)
- `done` output 1: one-cycle pulse on a successful commit
- `err` output 1: one-cycle pulse on a rejected frame

## Operation
- FSM states: `IDLE`, `SHIFT`, `OVER`.
- **`IDLE`**
  - `set_vars`=1: capture `sel`, clear the three shift words, write bit 0 from `expd`/`w`/`t`, set count=1, go to `SHIFT`.
- **`SHIFT`**
  - `set_vars`=1 and count<`DATA_W`: write bit[count], count+1.
  - `set_vars`=1 and count==`DATA_W`: the bit is discarded; go to `OVER`.
  - `set_vars`=0: evaluate the frame, then return to `IDLE`.
- **`OVER`**
  - `set_vars`=1: stay; bits are discarded.
  - `set_vars`=0: `err`, go to `IDLE`.
- **Evaluation** (on the `set_vars`=0 sample in `SHIFT`)
  - Commit only when count==`DATA_W` and captured `sel` < `N_NEURONS`.
  - Commit writes all three words to the selected neuron, sets `cfg_valid[sel]`, and pulses `done`.
  - Any other case pulses `err`; no output changes.
- Serial inputs are ignored in `IDLE` when `set_vars`=0.
- Writing one neuron never alters the other neurons' words.
- A neuron can be rewritten any number of times; the last successful frame wins.
- Count width is `$clog2(DATA_W+1)`; the count never wraps.
- **Reset**: all outputs 0 (`tau`, `weight`, `threshold`, `cfg_valid`, `busy`, `done`, `err`), FSM in `IDLE`, count 0.
  - Reset mid-frame aborts the frame with no `err` pulse.
  - Reset has priority over all other inputs.

## Timing
- The first high sample of `set_vars` is bit 0. Bit k is sampled on the k-th rising edge after that (k=0..`DATA_W`-1).
- `busy` rises the cycle after the first high sample. It falls on the same edge at which `done`/`err` assert.
- Commit latency: new values and `done` are visible one cycle after the first low sample of `set_vars`. `done`/`err` last exactly one cycle.
- Minimum inter-frame gap is one low cycle. A new frame may start on the cycle `done`/`err` is high.
- `sel` changes mid-frame have no effect.

## Structure
- **Shared package `lif_pkg`:**
  - `DATA_W_DEF`=8
  - `N_NEURONS_DEF`=4
  - loader state enum `{IDLE, SHIFT, OVER}`
  - helper function for count width
- **Sub-module `lif_ser_shift`** (param `DATA_W`): clear, indexed bit write, parallel word out. Instantiated three times (tau, weight, threshold), sharing the count from the parent FSM.
- The parent holds the FSM, count, captured `sel`, commit registers, and pulse generation.

## Test plan
All scenarios use `DATA_W`=8, `N_NEURONS`=4.

1. **Reset values:** `rst` high for 2 cycles → all outputs 0, `busy`=0.
2. **Single commit:** `sel`=2, 8-cycle frame with tau=0x5A, weight=0x3C, threshold=0x81 (LSB first) → one cycle after `set_vars` falls, `tau[23:16]`=0x5A, `weight[23:16]`=0x3C, `threshold[23:16]`=0x81, `cfg_valid`=4'b0100, `done` high 1 cycle; neurons 0,1,3 remain 0.
3. **Short and long frames:** 7-cycle frame, then 9-cycle frame, both to neuron 2 with 0xFF data → `err` pulses once per frame; neuron 2 keeps 0x5A/0x3C/0x81; `done` never asserts.
4. **Back-to-back commits:** frame to neuron 0 (tau=0x11), one low cycle, frame to neuron 3 (tau=0xEE), with `sel` toggled mid-frame → `tau`=0xEE000011, two `done` pulses, `cfg_valid`=4'b1001.
5. **Reset mid-frame:** assert `rst` on bit 4 of a frame to neuron 1 → all outputs 0 next cycle, no `err`. A fresh frame afterwards commits normally.
6. **Out-of-range select** (`N_NEURONS`=3): `sel`=3, full 8-cycle frame → `err` pulse, no output change.

Source files
------------

// File: rtl/lif_param_loader_pkg.sv
// Shared definitions for the LIF neuron parameter loader: defaults, FSM states, width helpers.
package lif_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned N_NEURONS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    OVER
  } loader_state_e;

  // Bits needed to count 0..data_w inclusive
  function automatic int unsigned cnt_width(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lif_param_loader_if.sv
// Host-side serial config bus and flat per-neuron parameter outputs of the loader.
interface lif_param_loader_if
  import lif_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned N_NEURONS = N_NEURONS_DEF,
  parameter int unsigned IDX_W     = idx_width(N_NEURONS)
) ();

  logic                          set_vars;
  logic [IDX_W-1:0]              sel;
  logic                          expd;
  logic                          w;
  logic                          t;
  logic [N_NEURONS*DATA_W-1:0]   tau;
  logic [N_NEURONS*DATA_W-1:0]   weight;
  logic [N_NEURONS*DATA_W-1:0]   threshold;
  logic [N_NEURONS-1:0]          cfg_valid;
  logic                          busy;
  logic                          done;
  logic                          err;

  modport master (
    output set_vars, sel, expd, w, t,
    input  tau, weight, threshold, cfg_valid, busy, done, err
  );

  modport slave (
    input  set_vars, sel, expd, w, t,
    output tau, weight, threshold, cfg_valid, busy, done, err
  );

endinterface

// File: rtl/lif_param_loader_ser_shift.sv
// Serial-to-parallel word assembler: clear plus indexed single-bit write.
module lif_ser_shift
  import lif_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           wr,
  input  logic [cnt_width(DATA_W)-1:0]   idx,
  input  logic                           bit_in,
  output logic [DATA_W-1:0]              word
);

  localparam int unsigned CNT_W = cnt_width(DATA_W);

  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] word_d;

  // Clear happens before the write so a frame's bit 0 lands in a fresh word
  always_comb begin
    word_d = clr ? '0 : word_q;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (wr && (idx == CNT_W'(i))) begin
        word_d[i] = bit_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/lif_param_loader.sv
// Frame-gated serial loader committing tau/weight/threshold words atomically to one neuron.
module lif_param_loader
  import lif_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned N_NEURONS = N_NEURONS_DEF,
  parameter int unsigned IDX_W     = idx_width(N_NEURONS)
) (
  input  logic             clk,
  input  logic             rst,
  lif_param_loader_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(DATA_W);
  localparam int unsigned BUS_W = N_NEURONS * DATA_W;

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  sh_idx;
  logic              sh_clr, sh_wr, commit;
  logic              done_d, err_d;
  logic              busy_q, done_q, err_q;

  logic [DATA_W-1:0] tau_word, weight_word, threshold_word;
  logic [BUS_W-1:0]  tau_q, weight_q, threshold_q;
  logic [N_NEURONS-1:0] cfg_valid_q;

  // Next-state, shift control and frame evaluation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    sh_idx  = cnt_q;
    sh_clr  = 1'b0;
    sh_wr   = 1'b0;
    commit  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.set_vars) begin
          sel_d   = bus.sel;
          sh_idx  = '0;
          sh_clr  = 1'b1;
          sh_wr   = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.set_vars) begin
          if (cnt_q < CNT_W'(DATA_W)) begin
            sh_wr = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            state_d = OVER;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          if ((cnt_q == CNT_W'(DATA_W)) && (32'(sel_q) < N_NEURONS)) begin
            commit = 1'b1;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      OVER: begin
        if (!bus.set_vars) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  lif_ser_shift #(.DATA_W(DATA_W)) u_tau_shift (
    .clk(clk), .rst(rst), .clr(sh_clr), .wr(sh_wr), .idx(sh_idx),
    .bit_in(bus.expd), .word(tau_word)
  );

  lif_ser_shift #(.DATA_W(DATA_W)) u_weight_shift (
    .clk(clk), .rst(rst), .clr(sh_clr), .wr(sh_wr), .idx(sh_idx),
    .bit_in(bus.w), .word(weight_word)
  );

  lif_ser_shift #(.DATA_W(DATA_W)) u_threshold_shift (
    .clk(clk), .rst(rst), .clr(sh_clr), .wr(sh_wr), .idx(sh_idx),
    .bit_in(bus.t), .word(threshold_word)
  );

  // State, pulses and per-neuron commit registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tau_q       <= '0;
      weight_q    <= '0;
      threshold_q <= '0;
      cfg_valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        if (commit && (sel_q == IDX_W'(i))) begin
          tau_q[i*DATA_W +: DATA_W]       <= tau_word;
          weight_q[i*DATA_W +: DATA_W]    <= weight_word;
          threshold_q[i*DATA_W +: DATA_W] <= threshold_word;
          cfg_valid_q[i]                  <= 1'b1;
        end
      end
    end
  end

  assign bus.tau       = tau_q;
  assign bus.weight    = weight_q;
  assign bus.threshold = threshold_q;
  assign bus.cfg_valid = cfg_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_lif_param_loader.sv
// Bench for lif_param_loader: two instances (4 and 3 neurons) driven identically, checked against a frame-level model.
module tb_lif_param_loader;
  import lif_pkg::*;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lif_param_loader_if #(.DATA_W(DW), .N_NEURONS(4)) if4 ();
  lif_param_loader_if #(.DATA_W(DW), .N_NEURONS(3)) if3 ();

  lif_param_loader #(.DATA_W(DW), .N_NEURONS(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
  lif_param_loader #(.DATA_W(DW), .N_NEURONS(3)) u3 (.clk(clk), .rst(rst), .bus(if3));

  int checks = 0;
  int errors = 0;

  // Model: index 0 is the 4-neuron instance, index 1 the 3-neuron one
  logic [7:0] m_tau [2][4];
  logic [7:0] m_wt  [2][4];
  logic [7:0] m_th  [2][4];
  logic [3:0] m_v   [2];

  function automatic int nn(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic logic [31:0] pack(input int d, input int kind);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nn(d); i++) begin
      case (kind)
        0:       r[i*8 +: 8] = m_tau[d][i];
        1:       r[i*8 +: 8] = m_wt[d][i];
        default: r[i*8 +: 8] = m_th[d][i];
      endcase
    end
    return r;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      m_v[d] = '0;
      for (int i = 0; i < 4; i++) begin
        m_tau[d][i] = '0;
        m_wt[d][i]  = '0;
        m_th[d][i]  = '0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_tau4"}, 32'(if4.tau), pack(0, 0));
    chk({tag, "_wt4"},  32'(if4.weight), pack(0, 1));
    chk({tag, "_th4"},  32'(if4.threshold), pack(0, 2));
    chk({tag, "_val4"}, 32'(if4.cfg_valid), 32'(m_v[0]));
    chk({tag, "_tau3"}, 32'(if3.tau), pack(1, 0));
    chk({tag, "_wt3"},  32'(if3.weight), pack(1, 1));
    chk({tag, "_th3"},  32'(if3.threshold), pack(1, 2));
    chk({tag, "_val3"}, 32'(if3.cfg_valid), 32'(m_v[1][2:0]));
  endtask

  task automatic drive(input logic sv, input logic [1:0] s, input logic e, input logic ww, input logic tt);
    if4.set_vars = sv; if4.sel = s; if4.expd = e; if4.w = ww; if4.t = tt;
    if3.set_vars = sv; if3.sel = s; if3.expd = e; if3.w = ww; if3.t = tt;
  endtask

  task automatic drive_idle();
    drive(1'b0, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      drive_idle();
      @(posedge clk);
      #1;
      chk("idle_pulses", 32'({if4.done, if4.err, if3.done, if3.err}), 32'(0));
      chk("idle_busy", 32'({if4.busy, if3.busy}), 32'(0));
    end
    if (n > 0) check_all("idle");
  endtask

  // One frame of len high cycles followed by a single low cycle; sel is scrambled after bit 0
  task automatic run_frame(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input int len);
    bit ok [2];
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        chk("busy_mid", 32'({if4.busy, if3.busy}), 32'(3));
        chk("pulse_mid", 32'({if4.done, if4.err, if3.done, if3.err}), 32'(0));
      end
      if (k < 8)
        drive(1'b1, (k == 0) ? s : 2'($urandom), a[k], b[k], c[k]);
      else
        drive(1'b1, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    drive_idle();
    for (int d = 0; d < 2; d++) begin
      ok[d] = (len == int'(DW)) && (int'(s) < nn(d));
      if (ok[d]) begin
        m_tau[d][s] = a;
        m_wt[d][s]  = b;
        m_th[d][s]  = c;
        m_v[d][s]   = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("done4", 32'(if4.done), 32'(ok[0]));
    chk("err4",  32'(if4.err), 32'(!ok[0]));
    chk("done3", 32'(if3.done), 32'(ok[1]));
    chk("err3",  32'(if3.err), 32'(!ok[1]));
    chk("busy_end", 32'({if4.busy, if3.busy}), 32'(0));
    check_all("frame");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    clear_model();
    check_all("rst");
    chk("rst_flags", 32'({if4.busy, if4.done, if4.err, if3.busy, if3.done, if3.err}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    clear_model();

    // Reset values
    do_reset();

    // Single commit to neuron 2
    run_frame(2'd2, 8'h5A, 8'h3C, 8'h81, 8);
    chk("t2_tau",  32'(if4.tau[23:16]), 32'h5A);
    chk("t2_wt",   32'(if4.weight[23:16]), 32'h3C);
    chk("t2_th",   32'(if4.threshold[23:16]), 32'h81);
    chk("t2_val",  32'(if4.cfg_valid), 32'b0100);
    chk("t2_rest", 32'(if4.tau) & 32'hFF00FFFF, 32'h0);
    idle(1);
    chk("t2_done_once", 32'(if4.done), 32'(0));

    // Short and long frames are rejected and leave neuron 2 untouched
    run_frame(2'd2, 8'hFF, 8'hFF, 8'hFF, 7);
    idle(1);
    run_frame(2'd2, 8'hFF, 8'hFF, 8'hFF, 9);
    chk("t3_tau", 32'(if4.tau[23:16]), 32'h5A);
    chk("t3_th",  32'(if4.threshold[23:16]), 32'h81);

    // Back-to-back commits with minimum gap
    do_reset();
    run_frame(2'd0, 8'h11, 8'h22, 8'h33, 8);
    run_frame(2'd3, 8'hEE, 8'hDD, 8'hCC, 8);
    chk("t4_tau", 32'(if4.tau), 32'hEE000011);
    chk("t4_val", 32'(if4.cfg_valid), 32'b1001);

    // Reset in the middle of a frame aborts it silently
    run_frame(2'd1, 8'h96, 8'h69, 8'hC3, 8);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, (k == 0) ? 2'd1 : 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 2'd1, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    clear_model();
    check_all("t5_rst");
    chk("t5_flags", 32'({if4.busy, if4.done, if4.err, if3.busy, if3.done, if3.err}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
    chk("t5_no_err", 32'({if4.err, if3.err, if4.busy}), 32'(0));
    run_frame(2'd1, 8'hA5, 8'h5A, 8'h0F, 8);
    chk("t5_tau", 32'(if4.tau[15:8]), 32'hA5);

    // Select 3 is out of range only for the 3-neuron instance
    run_frame(2'd3, 8'h77, 8'h88, 8'h99, 8);
    chk("t6_err3", 32'(if3.err), 32'(1));
    chk("t6_val3", 32'(if3.cfg_valid), 32'b010);

    // Randomized frames with mixed lengths and gaps
    for (int n = 0; n < 40; n++) begin
      int len;
      len = ($urandom_range(0, 2) != 0) ? 8 : int'($urandom_range(6, 10));
      idle(int'($urandom_range(0, 2)));
      run_frame(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), len);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
